// File: rtl/div_pkg.sv
// Shared constants and types for the iterative RV32M divider.
// Holds widths, op/state enums and the divide-by-zero quotient.
package div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ITER  = XLEN;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// Control-path bundle of the divider: start/kill/operands in,
// busy/valid/result out. master = control path, slave = divider.
interface div_if;
  import div_pkg::*;

  logic            start_i;
  logic            kill_i;
  div_op_e         op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, kill_i, op_i, a_i, b_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, kill_i, op_i, a_i, b_i,
    output busy_o, valid_o, result_o
  );

endinterface

// File: rtl/add_subtract.sv
// Shared ALU adder/subtractor: cin_i=1 gives a_i-b_i with
// cout_o as borrow; cin_i=0 gives a_i+b_i with cout_o as carry.
module add_subtract #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] b_eff;
  logic         carry;

  assign b_eff = cin_i ? ~b_i : b_i;
  assign {carry, sum_o} = {1'b0, a_i} + {1'b0, b_eff}
                        + (W+1)'(cin_i);
  // Two's-complement subtract: no carry out means a borrow.
  assign cout_o = cin_i ? ~carry : carry;

endmodule

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Ports: clk_i, rst_ni (async low), bus (div_if.slave).
// Option: DIV_ZERO_FAST_EN returns divide-by-zero results in 1 cycle.
module div_unit
  import div_pkg::*;
(
  input logic  clk_i,
  input logic  rst_ni,
  div_if.slave bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvd_q, dvd_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic             sel_r_q, sel_r_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             vld_q, vld_d;

  logic [XLEN-1:0] shifted, diff;
  logic [XLEN-1:0] q_fix, r_fix;
  logic [XLEN-1:0] a_l, b_l;
  logic            msb, borrow, ok;
  logic            b_zero, fix;

  assign shifted = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
  assign msb     = rem_q[XLEN-1];

  add_subtract #(.W(XLEN)) u_sub (
    .a_i    (shifted),
    .b_i    (dvs_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (borrow)
  );

  // msb set means the 33-bit partial remainder already exceeds dvs.
  assign ok = msb | ~borrow;

  // b==0 runs unsigned on raw a: quotient all ones, remainder a.
  assign b_zero = (bus.b_i == '0);
  assign fix    = ~bus.op_i[0] & ~b_zero;
  assign a_l    = (fix & bus.a_i[XLEN-1]) ? -bus.a_i : bus.a_i;
  assign b_l    = (fix & bus.b_i[XLEN-1]) ? -bus.b_i : bus.b_i;

  assign q_fix = negq_q ? -dvd_q : dvd_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    res_d   = res_q;
    sel_r_d = sel_r_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    vld_d   = 1'b0;
    if (bus.kill_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            sel_r_d = bus.op_i[1];
            negq_d  = fix & (bus.a_i[XLEN-1] ^ bus.b_i[XLEN-1]);
            negr_d  = fix & bus.a_i[XLEN-1];
            rem_d   = '0;
            cnt_d   = '0;
            dvd_d   = a_l;
            dvs_d   = b_l;
            state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
            if (b_zero) begin
              rem_d   = bus.a_i;
              dvd_d   = DIV_ZERO_Q;
              state_d = DONE;
            end
`endif
          end
        end
        CALC: begin
          rem_d = ok ? diff : shifted;
          dvd_d = {dvd_q[XLEN-2:0], ok};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          res_d   = sel_r_q ? r_fix : q_fix;
          vld_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      res_q   <= '0;
      sel_r_q <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
      sel_r_q <= sel_r_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.valid_o  = vld_q;
  assign bus.result_o = res_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases,
// ignored start, kill, mid-op reset and random ops vs a plain model.
module tb_div_unit;
  import div_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  div_if bus ();

  div_unit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input div_op_e op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      OP_DIV:
        if (b == 0) return 32'hFFFF_FFFF;
        else if (ovf) return 32'h8000_0000;
        else return $signed(a) / $signed(b);
      OP_DIVU:
        if (b == 0) return 32'hFFFF_FFFF;
        else return a / b;
      OP_REM:
        if (b == 0) return a;
        else if (ovf) return 32'h0;
        else return $signed(a) % $signed(b);
      default:
        if (b == 0) return a;
        else return a % b;
    endcase
  endfunction

  // Starts an op in the current cycle (call #1 after a posedge).
  // poke>0 pulses a second start at that cycle while busy.
  task automatic run_op(input div_op_e op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int poke);
    int lat;
    int exp_lat;
    logic [31:0] exp;
    exp = ref_div(op, a, b);
    exp_lat = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 0) exp_lat = 1;
`endif
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    check_eq("busy_acc", 32'(bus.busy_o), 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1 bus.start_i = 1'b0;
      if (bus.valid_o) break;
      if (poke != 0 && lat == poke) begin
        bus.op_i    = OP_DIVU;
        bus.a_i     = 32'd99;
        bus.b_i     = 32'd3;
        bus.start_i = 1'b1;
      end
    end
    check_eq("lat", 32'(lat), 32'(exp_lat));
    check_eq("res", bus.result_o, exp);
  endtask

  initial begin
    int seen;
    div_op_e rop;
    logic [31:0] ra, rb;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.kill_i  = 1'b0;
    bus.op_i    = OP_DIV;
    bus.a_i     = '0;
    bus.b_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("rst_vld", 32'(bus.valid_o), 32'd0);
    check_eq("rst_res", bus.result_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(OP_DIVU, 32'd100, 32'd7, 0);
    run_op(OP_REMU, 32'd100, 32'd7, 0);
    run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0);
    run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(OP_DIVU, 32'd123, 32'd0, 0);
    run_op(OP_DIVU, 32'd50, 32'd5, 10);

    // kill at cycle 5 of a new op
    bus.op_i    = OP_DIVU;
    bus.a_i     = 32'd1000;
    bus.b_i     = 32'd3;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.kill_i = 1'b1;
    @(posedge clk);
    #1 bus.kill_i = 1'b0;
    check_eq("kill_busy", 32'(bus.busy_o), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.valid_o) seen++;
    end
    check_eq("kill_novld", 32'(seen), 32'd0);
    check_eq("kill_res", bus.result_o, 32'd10);

    for (int i = 0; i < 40; i++) begin
      rop = div_op_e'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFF_FFFF;
        3: rb = ra >> $urandom_range(1, 31);
        4: rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 0);
    end

    // reset in the middle of an operation
    bus.op_i    = OP_DIVU;
    bus.a_i     = 32'd77777;
    bus.b_i     = 32'd13;
    bus.start_i = 1'b1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", 32'(bus.busy_o), 32'd0);
    check_eq("mrst_vld", 32'(bus.valid_o), 32'd0);
    check_eq("mrst_res", bus.result_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (bus.valid_o) seen++;
    end
    check_eq("mrst_novld", 32'(seen), 32'd0);
    run_op(OP_REMU, 32'd100, 32'd7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
